// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / register interface and the rx byte FIFO.
// The master side drives pushes, pops and the overrun clear; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          rd_pop;
  logic          overrun_clr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          full;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overrun;

  modport master (
    output in_data, in_valid, rd_pop, overrun_clr,
    input  rd_data, rd_valid, full, almost_full, count, overrun
  );

  modport slave (
    input  in_data, in_valid, rd_pop, overrun_clr,
    output rd_data, rd_valid, full, almost_full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with first-word-fall-through head and a sticky overrun flag.
// Occupancy lives in its own register; every output derives from registered state only.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovr;

  logic pop_ok;
  logic push_ok;
  logic drop;

  // A pop in the same cycle frees the slot, so a full queue still accepts the byte.
  assign pop_ok  = bus.rd_pop && (cnt != '0);
  assign push_ok = bus.in_valid && ((cnt != FULL_CNT) || pop_ok);
  assign drop    = bus.in_valid && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                 ovr <= 1'b1;
      else if (bus.overrun_clr) ovr <= 1'b0;
    end
  end

  always_comb begin
    bus.rd_data     = (cnt != '0) ? mem[rd_ptr] : 8'h00;
    bus.rd_valid    = (cnt != '0);
    bus.full        = (cnt == FULL_CNT);
    bus.almost_full = (cnt >= AF_CNT);
    bus.count       = cnt;
    bus.overrun     = ovr;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the bus-facing register interface.
- Upstream: accepts bytes from the receiver's one-cycle data-ready pulse.
- Downstream: the register interface pops bytes one per bus read.
- Replaces the single rx holding register. Back-to-back frames are no longer lost when the CPU reads slowly.
- Flags overflow with a sticky overrun bit.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2.
AF_LEVEL, 12, count at or above which almost_full asserts; 1..DEPTH.

Ports:
clk  input  1  system clock (16 MHz board clock); all logic on rising edge.
rst  input  1  synchronous reset, active-high.
in_data  input  8  received byte; sampled only when in_valid=1.
in_valid  input  1  one-cycle push strobe from receiver (data_ready).
rd_pop  input  1  one-cycle pop strobe from register interface.
rd_data  output  8  head-of-queue byte (first-word-fall-through).
rd_valid  output  1  queue non-empty.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_LEVEL.
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
overrun  output  1  sticky: a byte was dropped because the queue was full.
overrun_clr  input  1  one-cycle strobe clearing overrun.

Behaviour:
Reset:
- rst=1 at a rising edge sets wr_ptr=rd_ptr=0 and count=0.
- overrun=0, rd_valid=0, full=0, almost_full=0, rd_data=8'h00.
- Reset overrides all other inputs in the same cycle.
- Reset mid-burst discards all stored bytes.

Storage and pointers:
- DEPTH x 8 memory.
- wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally DEPTH-1 -> 0.
- count is tracked in a separate register, not derived from the pointers.

Push:
- Occurs when in_valid=1 and (count<DEPTH or pop accepted in the same cycle).
- Writes mem[wr_ptr] and increments wr_ptr.

Pop:
- Accepted when rd_pop=1 and count>0; increments rd_ptr.
- Pop when empty is ignored: no pointer change, no error flag.

Simultaneous events:
- Push and pop both accepted: count unchanged, both pointers advance.
- Full with in_valid and accepted pop: byte stored, no overrun.
- Full with in_valid and no pop: byte dropped, memory and pointers unchanged, overrun<=1.
- Empty with in_valid and rd_pop: push only, pop ignored, count becomes 1.

Count: count <= count + push - pop, where push and pop are the accepted events. Never exceeds DEPTH, never underflows.

Latency:
- A byte pushed at edge N is visible on rd_data with rd_valid=1 after edge N (combinationally from registered state).
- Zero-cycle read latency for the head entry.
- After an accepted pop at edge N, rd_data shows the next entry after edge N.

rd_data:
- Equals mem[rd_ptr] when count>0.
- Forced to 8'h00 when count==0. The bus never sees stale data.

Flags:
- full, almost_full and rd_valid are pure functions of the registered count.

overrun:
- Set by a drop and cleared by overrun_clr.
- Set and clear in the same cycle: set wins, overrun stays 1.
- Persists across pops until cleared.

No combinational path from in_valid or rd_pop to any output.

Test Plan:
1. Reset, push 8'hA5 (one in_valid pulse) -> next cycle rd_valid=1, rd_data=8'hA5, count=1. Then rd_pop pulse -> rd_valid=0, rd_data=8'h00, count=0.
2. Push 16 bytes 8'h00..8'h0F with no pops -> almost_full asserts when count reaches 12, full=1 at count 16. Then 16 pops return 8'h00..8'h0F in order, then empty.
3. Full queue, push 8'hFF with no pop -> overrun=1, count stays 16, head still 8'h00. Pulse overrun_clr together with a new dropped push -> overrun remains 1. Pulse overrun_clr alone -> overrun=0.
4. Full queue, push 8'h77 and pop in the same cycle -> count stays 16, overrun=0, 8'h77 is the last byte popped.
5. Empty queue, rd_pop only -> count 0, no change. Empty queue, in_valid=8'h3C and rd_pop together -> count=1, rd_data=8'h3C.
6. Wrap: push/pop 40 bytes interleaved so pointers wrap twice -> data order preserved. Assert rst with count=5 -> next cycle count=0, rd_valid=0, overrun=0, rd_data=8'h00.
